// File: rtl/poly_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_sweep_pkg
//  Description : Shared types and constants for the polynomial-checker sweep
//                driver: FSM state encoding, LFSR taps, seed masks, operand
//                widths, corner-vector constants and operand mapping helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Operand widths of the checker inputs
    localparam int c_op_a_w = 12;   // I1..I3
    localparam int c_op_b_w = 22;   // I4..I6

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] c_lfsr_taps = 32'h8020_0003;

    // Per-LFSR seed decorrelation masks
    localparam logic [31:0] c_seed_xor_b = 32'h5555_5555;
    localparam logic [31:0] c_seed_xor_d = 32'hA5A5_A5A5;

    // One complete operand set for the checker, I1 in the MSBs
    typedef struct packed {
        logic [c_op_a_w-1:0] i1;
        logic [c_op_a_w-1:0] i2;
        logic [c_op_a_w-1:0] i3;
        logic [c_op_b_w-1:0] i4;
        logic [c_op_b_w-1:0] i5;
        logic [c_op_b_w-1:0] i6;
    } op_vec_t;

    // Fixed corner vectors driven ahead of the pseudo-random stream
    localparam op_vec_t c_corner_0 = '0;
    localparam op_vec_t c_corner_1 = '1;
    localparam op_vec_t c_corner_2 = {{3{{c_op_a_w{1'b1}}}}, {3{{c_op_b_w{1'b0}}}}};
    localparam op_vec_t c_corner_3 = {{3{{c_op_a_w{1'b0}}}}, {3{{c_op_b_w{1'b1}}}}};

    // An all-zero LFSR state would lock up, so it is replaced by 1
    function automatic logic [31:0] fix_seed(input logic [31:0] seed);
        return (seed == 32'h0) ? 32'h1 : seed;
    endfunction

    // Map the four LFSR states onto the six checker operands
    function automatic op_vec_t lfsr_to_ops(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] c,
                                            input logic [31:0] d);
        op_vec_t v;
        v.i1 = a[11:0];
        v.i2 = a[23:12];
        v.i3 = b[11:0];
        v.i4 = c[21:0];
        v.i5 = d[21:0];
        v.i6 = {b[31:12], a[25:24]};
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : poly_lfsr32
//  Description : 32-bit Galois LFSR with synchronous seed load and step
//                enable. Resets to its (non-zero) seed.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_lfsr32
    import poly_sweep_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    output logic [31:0] o_state
);

    localparam logic [31:0] c_seed = fix_seed(SEED);

    logic [31:0] r_state;

    // State register: load wins over step so a reseed always restarts cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_seed;
        end else if (i_load) begin
            r_state <= c_seed;
        end else if (i_step) begin
            r_state <= {1'b0, r_state[31:1]} ^ (r_state[0] ? c_lfsr_taps : 32'h0);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/poly_sweep_drv.sv
`default_nettype none
// ============================================================================
//  Module      : poly_sweep_drv
//  Description : Drives a deterministic operand sweep into the combinational
//                polynomial checker, samples its verdict LAT cycles later and
//                accumulates fail count and first failing index.
//                Optional macro POLY_SWEEP_CORNER_EN prepends four fixed
//                corner vectors (indices 0..3) to the LFSR stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_sweep_drv
    import poly_sweep_pkg::*;
#(
    parameter int          N_VEC = 1024,
    parameter int          CNT_W = 16,
    parameter int          LAT   = 0,
    parameter logic [31:0] SEED  = 32'hACE1_2B3D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [11:0]      vec_i1,
    output logic [11:0]      vec_i2,
    output logic [11:0]      vec_i3,
    output logic [21:0]      vec_i4,
    output logic [21:0]      vec_i5,
    output logic [21:0]      vec_i6,
    input  logic             o1,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx
);

`ifdef POLY_SWEEP_CORNER_EN
    localparam int c_n_corner = 4;
`else
    localparam int c_n_corner = 0;
`endif

    localparam int               c_total    = N_VEC + c_n_corner;
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(c_total - 1);
    localparam logic [1:0]       c_lat_m1   = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

    localparam logic [31:0] c_seed_a = fix_seed(SEED);
    localparam logic [31:0] c_seed_b = fix_seed(SEED ^ c_seed_xor_b);
    localparam logic [31:0] c_seed_c = fix_seed(~SEED);
    localparam logic [31:0] c_seed_d = fix_seed(SEED ^ c_seed_xor_d);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_idx;
    logic [1:0]       r_drain_cnt;
    logic             r_vec_vld;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_ff_vld;
    logic [CNT_W-1:0] r_ff_idx;

    logic             w_accept;
    logic             w_drive;
    logic             w_last;
    logic             w_in_corner;
    logic             w_step;
    logic             w_res_vld;
    logic [CNT_W-1:0] w_res_idx;
    logic [31:0]      w_lfsr_a;
    logic [31:0]      w_lfsr_b;
    logic [31:0]      w_lfsr_c;
    logic [31:0]      w_lfsr_d;
    op_vec_t          w_ops;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_drive  = (r_state == ST_RUN);
    assign w_last   = (r_idx == c_last_idx);

`ifdef POLY_SWEEP_CORNER_EN
    assign w_in_corner = (r_idx < CNT_W'(c_n_corner));
`else
    assign w_in_corner = 1'b0;
`endif

    // The LFSRs hold the vector currently on the bus; they advance only
    // between two LFSR vectors so the last one stays visible after the sweep.
    assign w_step = w_drive && !w_last && !w_in_corner;

    // ------------------------------------------------------------------
    // Stimulus generators
    // ------------------------------------------------------------------
    poly_lfsr32 #(.SEED(c_seed_a)) u_lfsr_a (
        .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_step(w_step), .o_state(w_lfsr_a)
    );
    poly_lfsr32 #(.SEED(c_seed_b)) u_lfsr_b (
        .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_step(w_step), .o_state(w_lfsr_b)
    );
    poly_lfsr32 #(.SEED(c_seed_c)) u_lfsr_c (
        .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_step(w_step), .o_state(w_lfsr_c)
    );
    poly_lfsr32 #(.SEED(c_seed_d)) u_lfsr_d (
        .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_step(w_step), .o_state(w_lfsr_d)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = (LAT > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == c_lat_m1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Vector index, drain counter and output-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_drain_cnt <= 2'd0;
            r_vec_vld   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx     <= '0;
                r_vec_vld <= 1'b1;
            end else if (w_drive && !w_last) begin
                r_idx <= r_idx + CNT_W'(1);
            end

            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 2'd1;
            end else begin
                r_drain_cnt <= 2'd0;
            end
        end
    end

    // Operand selection: zeros until the first sweep, corners, then LFSRs
    always_comb begin
        w_ops = lfsr_to_ops(w_lfsr_a, w_lfsr_b, w_lfsr_c, w_lfsr_d);
`ifdef POLY_SWEEP_CORNER_EN
        if (w_in_corner) begin
            case (r_idx[1:0])
                2'd0:    w_ops = c_corner_0;
                2'd1:    w_ops = c_corner_1;
                2'd2:    w_ops = c_corner_2;
                default: w_ops = c_corner_3;
            endcase
        end
`endif
        if (!r_vec_vld) begin
            w_ops = '0;
        end
    end

    assign vec_i1 = w_ops.i1;
    assign vec_i2 = w_ops.i2;
    assign vec_i3 = w_ops.i3;
    assign vec_i4 = w_ops.i4;
    assign vec_i5 = w_ops.i5;
    assign vec_i6 = w_ops.i6;

    // ------------------------------------------------------------------
    // Result alignment: carry valid and index alongside the checker latency
    // ------------------------------------------------------------------
    generate
        if (LAT == 0) begin : g_lat0
            assign w_res_vld = w_drive;
            assign w_res_idx = r_idx;
        end else begin : g_latn
            logic [LAT-1:0]   r_pipe_vld;
            logic [CNT_W-1:0] r_pipe_idx [LAT];

            // Shift register tracking which vector each verdict belongs to
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe_vld <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        r_pipe_idx[i] <= '0;
                    end
                end else begin
                    r_pipe_vld[0] <= w_drive;
                    r_pipe_idx[0] <= r_idx;
                    for (int i = 1; i < LAT; i++) begin
                        r_pipe_vld[i] <= r_pipe_vld[i-1];
                        r_pipe_idx[i] <= r_pipe_idx[i-1];
                    end
                end
            end

            assign w_res_vld = r_pipe_vld[LAT-1];
            assign w_res_idx = r_pipe_idx[LAT-1];
        end
    endgenerate

    // Statistics: cleared on an accepted start, held after the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
        end else if (w_accept) begin
            r_fail_cnt <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
        end else if (w_res_vld && !o1) begin
            if (r_fail_cnt != {CNT_W{1'b1}}) begin
                r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
            if (!r_ff_vld) begin
                r_ff_vld <= 1'b1;
                r_ff_idx <= w_res_idx;
            end
        end
    end

    assign fail_cnt       = r_fail_cnt;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_idx = r_ff_idx;

endmodule
`default_nettype wire
